// File: rtl/baud_gen_frac.sv
// Fractional-divisor oversample/mid-bit/bit-boundary tick generator with a shadowed
// run-time divisor. Define BAUD_LEGACY_CLK_EN to add the toggling baud_clk output.
module baud_gen_frac #(
  parameter int IW        = 16,
  parameter int FW        = 4,
  parameter int OSR       = 16,
  parameter int DEF_DIV_I = 27,
  parameter int DEF_DIV_F = 0
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_l,
  input  logic                   en,
  input  logic [IW-1:0]          div_i,
  input  logic [FW-1:0]          div_f,
  input  logic                   div_wr,
  input  logic                   restart,
  output logic                   os_tick,
  output logic                   mid_tick,
  output logic                   bit_tick,
  output logic [$clog2(OSR)-1:0] os_cnt,
  output logic                   cfg_pending
`ifdef BAUD_LEGACY_CLK_EN
  ,
  output logic                   baud_clk
`endif
);
  localparam int             OSW     = $clog2(OSR);
  localparam logic [IW-1:0]  RST_I   = IW'(DEF_DIV_I);
  localparam logic [FW-1:0]  RST_F   = FW'(DEF_DIV_F);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OSR - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OSR / 2);

  logic [IW-1:0]  act_i_r, shd_i_r, cnt_r, d_eff_s, shd_i_nxt_s;
  logic [FW-1:0]  act_f_r, shd_f_r, acc_r, shd_f_nxt_s;
  logic [FW:0]    acc_sum_s;
  logic [IW:0]    period_s;
  logic [OSW-1:0] os_nxt_s;
  logic           wrap_s, bit_wrap_s;

  // Period of the current oversample slot and the wrap decisions derived from it
  always_comb begin
    if (act_i_r == {IW{1'b0}}) begin
      d_eff_s = {{(IW-1){1'b0}}, 1'b1};
    end else begin
      d_eff_s = act_i_r;
    end
    if (div_wr) begin
      shd_i_nxt_s = div_i;
      shd_f_nxt_s = div_f;
    end else begin
      shd_i_nxt_s = shd_i_r;
      shd_f_nxt_s = shd_f_r;
    end
    acc_sum_s  = {1'b0, acc_r} + {1'b0, act_f_r};
    period_s   = {1'b0, d_eff_s} + {{IW{1'b0}}, acc_sum_s[FW]};
    // >= rather than == so a divisor shrunk while frozen still wraps cleanly
    wrap_s     = ({1'b0, cnt_r} >= (period_s - {{IW{1'b0}}, 1'b1}));
    os_nxt_s   = os_cnt + {{(OSW-1){1'b0}}, 1'b1};
    bit_wrap_s = wrap_s && (os_cnt == OS_LAST);
  end

  // Phase counters, tick outputs and divisor shadow/active registers
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      act_i_r     <= RST_I;
      act_f_r     <= RST_F;
      shd_i_r     <= RST_I;
      shd_f_r     <= RST_F;
      cnt_r       <= {IW{1'b0}};
      acc_r       <= {FW{1'b0}};
      os_cnt      <= {OSW{1'b0}};
      os_tick     <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      shd_i_r <= shd_i_nxt_s;
      shd_f_r <= shd_f_nxt_s;
      if (restart) begin
        cnt_r       <= {IW{1'b0}};
        acc_r       <= {FW{1'b0}};
        os_cnt      <= {OSW{1'b0}};
        os_tick     <= 1'b0;
        mid_tick    <= 1'b0;
        bit_tick    <= 1'b0;
        act_i_r     <= shd_i_nxt_s;
        act_f_r     <= shd_f_nxt_s;
        cfg_pending <= 1'b0;
      end else if (!en) begin
        os_tick     <= 1'b0;
        mid_tick    <= 1'b0;
        bit_tick    <= 1'b0;
        act_i_r     <= shd_i_nxt_s;
        act_f_r     <= shd_f_nxt_s;
        cfg_pending <= 1'b0;
      end else if (wrap_s) begin
        cnt_r    <= {IW{1'b0}};
        acc_r    <= acc_sum_s[FW-1:0];
        os_cnt   <= os_nxt_s;
        os_tick  <= 1'b1;
        mid_tick <= (os_nxt_s == OS_MID);
        bit_tick <= bit_wrap_s;
        if (bit_wrap_s) begin
          // shadow equals active when nothing is pending, so this copy is harmless then
          act_i_r     <= shd_i_r;
          act_f_r     <= shd_f_r;
          cfg_pending <= div_wr;
        end else begin
          cfg_pending <= cfg_pending | div_wr;
        end
      end else begin
        cnt_r       <= cnt_r + {{(IW-1){1'b0}}, 1'b1};
        os_tick     <= 1'b0;
        mid_tick    <= 1'b0;
        bit_tick    <= 1'b0;
        cfg_pending <= cfg_pending | div_wr;
      end
    end
  end

`ifdef BAUD_LEGACY_CLK_EN
  // Legacy half-rate clock flips together with every oversample tick
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      baud_clk <= 1'b0;
    end else if (en && !restart && wrap_s) begin
      baud_clk <= ~baud_clk;
    end else begin
      baud_clk <= baud_clk;
    end
  end
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: closed-form tick-time model plus directed checks.
module tb_baud_gen_frac;
  localparam int IW = 16;
  localparam int FW = 4;
  localparam int OSR = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_l = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_i = 16'd0;
  logic [3:0]  div_f = 4'd0;
  logic        div_wr = 1'b0;
  logic        restart = 1'b0;
  logic        os_tick, mid_tick, bit_tick, cfg_pending;
  logic [3:0]  os_cnt;
`ifdef BAUD_LEGACY_CLK_EN
  logic        baud_clk;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  baud_gen_frac #(.IW(IW), .FW(FW), .OSR(OSR), .DEF_DIV_I(27), .DEF_DIV_F(0)) dut (
    .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .en(en), .div_i(div_i), .div_f(div_f),
    .div_wr(div_wr), .restart(restart), .os_tick(os_tick), .mid_tick(mid_tick),
    .bit_tick(bit_tick), .os_cnt(os_cnt), .cfg_pending(cfg_pending)
`ifdef BAUD_LEGACY_CLK_EN
    , .baud_clk(baud_clk)
`endif
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Model: tick n of an epoch lands after n*D + floor((a0 + n*F)/2^FW) enabled cycles
  int m_et = 0, m_n = 0, m_a0 = 0, m_osi = 0;
  int m_ai = 27, m_af = 0, m_si = 27, m_sf = 0;
  logic m_pend = 1'b0, m_os = 1'b0, m_mid = 1'b0, m_bit = 1'b0, m_bclk = 1'b0;

  task automatic model_step();
    int ni, nf, d;
    if (!sys_rst_l) begin
      m_ai = 27; m_af = 0; m_si = 27; m_sf = 0; m_pend = 1'b0;
      m_et = 0; m_n = 0; m_a0 = 0; m_osi = 0;
      m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0; m_bclk = 1'b0;
      return;
    end
    ni = div_wr ? int'(div_i) : m_si;
    nf = div_wr ? int'(div_f) : m_sf;
    m_os = 1'b0; m_mid = 1'b0; m_bit = 1'b0;
    if (restart) begin
      m_ai = ni; m_af = nf; m_pend = 1'b0;
      m_et = 0; m_n = 0; m_a0 = 0; m_osi = 0;
    end else if (!en) begin
      m_ai = ni; m_af = nf; m_pend = 1'b0;
    end else begin
      d = (m_ai == 0) ? 1 : m_ai;
      m_et++;
      if (m_et == (m_n + 1) * d + ((m_a0 + (m_n + 1) * m_af) >> FW)) begin
        m_os = 1'b1; m_n++; m_bclk = ~m_bclk;
        m_osi = (m_osi + 1) % OSR;
        m_mid = (m_osi == OSR / 2);
        m_bit = (m_osi == 0);
        if (m_bit) begin
          if (m_pend) begin
            m_a0 = (m_a0 + m_n * m_af) % (1 << FW);
            m_n = 0; m_et = 0; m_ai = m_si; m_af = m_sf;
          end
          m_pend = div_wr;
        end else begin
          m_pend = m_pend | div_wr;
        end
      end else begin
        m_pend = m_pend | div_wr;
      end
    end
    m_si = ni; m_sf = nf;
  endtask

  always @(posedge sys_clk or negedge sys_rst_l) model_step();

  task automatic cmp_step();
    tests++;
    if ({os_tick, mid_tick, bit_tick, cfg_pending} !== {m_os, m_mid, m_bit, m_pend} ||
        os_cnt !== 4'(m_osi)) begin
      fails++;
      $display("FAIL model_cmp cyc=%0d got os/mid/bit/pend=%b%b%b%b os_cnt=%0d expected %b%b%b%b os_cnt=%0d",
               cyc, os_tick, mid_tick, bit_tick, cfg_pending, os_cnt,
               m_os, m_mid, m_bit, m_pend, m_osi);
    end
`ifdef BAUD_LEGACY_CLK_EN
    tests++;
    if (baud_clk !== m_bclk) begin
      fails++;
      $display("FAIL baud_clk_cmp cyc=%0d got %b expected %b", cyc, baud_clk, m_bclk);
    end
`endif
  endtask

  always @(negedge sys_clk) cmp_step();

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // which: 0 os_tick, 1 mid_tick, 2 bit_tick; at = cycle seen, -1 on timeout
  task automatic wait_ev(input int which, input int limit, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      case (which)
        0: s = os_tick;
        1: s = mid_tick;
        default: s = bit_tick;
      endcase
      if (s === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_timeout: event %0d not seen within %0d cycles", which, limit);
    end
  endtask

  initial begin
    int t0, tb0, at, nt;
    repeat (3) @(negedge sys_clk);
    chk("reset_outs", int'({os_tick, mid_tick, bit_tick, cfg_pending, os_cnt}), 0);

    // defaults 27.0
    sys_rst_l = 1'b1; en = 1'b1; t0 = cyc;
    wait_ev(0, 100, at);  chk("t1_first_os", at - t0, 27);
    wait_ev(1, 1000, at); chk("t1_first_mid", at - t0, 216);
    wait_ev(2, 1000, at); chk("t1_first_bit", at - t0, 432); tb0 = at;
    wait_ev(1, 1000, at); chk("t1_mid_after_bit", at - tb0, 216);
    wait_ev(2, 1000, at); chk("t1_bit_spacing", at - tb0, 432);

    // 10.5 via write then restart
    div_i = 16'd10; div_f = 4'd8; div_wr = 1'b1;
    @(negedge sys_clk); div_wr = 1'b0;
    chk("t2_pending_set", int'(cfg_pending), 1);
    restart = 1'b1;
    @(negedge sys_clk); restart = 1'b0;
    chk("t2_pending_clr", int'(cfg_pending), 0);
    chk("t2_os_cnt_zero", int'(os_cnt), 0);
    t0 = cyc;
    wait_ev(0, 50, at);  chk("t2_os1", at - t0, 10);
    wait_ev(0, 50, at);  chk("t2_os2", at - t0, 21);
    wait_ev(2, 400, at); chk("t2_bit1", at - t0, 168);
    wait_ev(2, 400, at); chk("t2_bit2_32ticks", at - t0, 336);

    // write 20.0 mid-bit while running
    repeat (5) wait_ev(0, 50, at);
    tb0 = at;
    chk("t3_os_cnt5", int'(os_cnt), 5);
    div_i = 16'd20; div_f = 4'd0; div_wr = 1'b1;
    @(negedge sys_clk); div_wr = 1'b0;
    chk("t3_pending", int'(cfg_pending), 1);
    wait_ev(2, 400, at); chk("t3_old_period_kept", at - tb0, 116);
    chk("t3_pending_clr", int'(cfg_pending), 0);
    tb0 = at;
    wait_ev(0, 50, at); chk("t3_new_period", at - tb0, 20);

    // freeze at os_cnt=7, cnt=3
    repeat (6) wait_ev(0, 50, at);
    chk("t4_os_cnt7", int'(os_cnt), 7);
    repeat (3) @(negedge sys_clk);
    en = 1'b0; nt = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (os_tick || mid_tick || bit_tick) nt++;
    end
    chk("t4_no_ticks", nt, 0);
    chk("t4_held_os_cnt", int'(os_cnt), 7);
    en = 1'b1; t0 = cyc;
    wait_ev(0, 50, at); chk("t4_resume_remaining", at - t0, 17);
    chk("t4_os_cnt8", int'(os_cnt), 8);

    // restart together with div_wr 5.0
    div_i = 16'd5; div_wr = 1'b1; restart = 1'b1;
    @(negedge sys_clk); div_wr = 1'b0; restart = 1'b0;
    chk("t5_pending0", int'(cfg_pending), 0);
    chk("t5_os_cnt0", int'(os_cnt), 0);
    t0 = cyc;
    wait_ev(0, 20, at); chk("t5_first_os", at - t0, 5);
    div_i = 16'd0; div_wr = 1'b1; restart = 1'b1;
    @(negedge sys_clk); div_wr = 1'b0; restart = 1'b0;
    nt = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (os_tick) nt++;
    end
    chk("t5_continuous", nt, 8);

    // write landing on the bit-tick edge while an earlier write is pending
    for (int i = 0; i < 40 && os_cnt != 4'd10; i++) @(negedge sys_clk);
    chk("t5b_os_cnt10", int'(os_cnt), 10);
    div_i = 16'd3; div_wr = 1'b1;
    @(negedge sys_clk); div_wr = 1'b0;
    for (int i = 0; i < 40 && os_cnt != 4'd15; i++) @(negedge sys_clk);
    div_i = 16'd4; div_wr = 1'b1;
    @(negedge sys_clk); div_wr = 1'b0;
    chk("t5b_bit_edge", int'(bit_tick), 1);
    chk("t5b_new_pending", int'(cfg_pending), 1);
    tb0 = cyc;
    wait_ev(0, 10, at);  chk("t5b_old_applied", at - tb0, 3);
    wait_ev(2, 100, at); chk("t5b_bit_span", at - tb0, 48);
    chk("t5b_pending_clr", int'(cfg_pending), 0);
    tb0 = at;
    wait_ev(0, 10, at);  chk("t5b_second_applied", at - tb0, 4);

    // async reset mid-bit with a pending write
    div_i = 16'd7; div_wr = 1'b1;
    @(negedge sys_clk); div_wr = 1'b0;
    chk("t6_pending", int'(cfg_pending), 1);
    @(negedge sys_clk);
    #2 sys_rst_l = 1'b0;
    #1 chk("t6_async_zero", int'({os_tick, mid_tick, bit_tick, cfg_pending, os_cnt}), 0);
`ifdef BAUD_LEGACY_CLK_EN
    chk("t6_baud_clk_zero", int'(baud_clk), 0);
`endif
    @(negedge sys_clk); sys_rst_l = 1'b1; t0 = cyc;
    wait_ev(0, 100, at); chk("t6_default_div", at - t0, 27);
    repeat (30) @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
